// File: rtl/nec_pkg.sv
// Shared NEC IR definitions: transmitter states, default timing at 50 MHz,
// command codes used by the calculator, and the frame builder.
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } nec_state_t;

  // Default timing in clk cycles at 50 MHz
  localparam int NEC_T_LEAD_MARK  = 450000;
  localparam int NEC_T_LEAD_SPACE = 225000;
  localparam int NEC_T_REP_SPACE  = 112500;
  localparam int NEC_T_BIT_MARK   = 28125;
  localparam int NEC_T_ZERO_SPACE = 28125;
  localparam int NEC_T_ONE_SPACE  = 84375;
  localparam int NEC_T_GAP        = 1500000;
  localparam int NEC_CARRIER_HALF = 658;
  localparam int NEC_CNT_W        = 21;

  // Command codes understood by the calculator receiver
  localparam logic [7:0] NEC_CMD_POWER     = 8'h12;
  localparam logic [7:0] NEC_CMD_CLEAR_A   = 8'h0F;
  localparam logic [7:0] NEC_CMD_CLEAR_ALL = 8'h10;
  localparam logic [7:0] NEC_CMD_CLEAR_B   = 8'h13;
  localparam logic [7:0] NEC_CMD_ADD       = 8'h1A;
  localparam logic [7:0] NEC_CMD_SUB       = 8'h1E;
  localparam logic [7:0] NEC_CMD_SIGN      = 8'h0C;

  // 32-bit word sent LSB-first: addr, ~addr, cmd, ~cmd
  function automatic logic [31:0] build_frame(input logic [7:0] addr,
                                              input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  // States in which the IR line carries a mark (line low)
  function automatic logic is_mark_state(input nec_state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// 38 kHz carrier for the IR LED. Runs only while enabled (mark), restarts
// high on every mark entry, and holds the LED off otherwise.
module nec_carrier_gen
  import nec_pkg::*;
#(
  parameter int CARRIER_HALF = NEC_CARRIER_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_phase_reset,
  output logic o_led
);

  localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [PW-1:0] PHASE_END = PW'(CARRIER_HALF - 1);

  logic [PW-1:0] r_phase_cnt;
  logic          r_led;

  // Half-period counter; inputs describe the next cycle so o_led lines up with the registered ir_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase_cnt <= '0;
      r_led       <= 1'b0;
    end else if (!i_enable) begin
      r_phase_cnt <= '0;
      r_led       <= 1'b0;
    end else if (i_phase_reset) begin
      r_phase_cnt <= '0;
      r_led       <= 1'b1;
    end else if (r_phase_cnt == PHASE_END) begin
      r_phase_cnt <= '0;
      r_led       <= ~r_led;
    end else begin
      r_phase_cnt <= r_phase_cnt + PW'(1);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/nec_ir_tx.sv
// NEC IR transmitter: leader, 32 pulse-distance bits LSB-first, stop burst
// and guard gap, or the short repeat code. All outputs are registered from
// the next state so the line only changes at state boundaries.
module nec_ir_tx
  import nec_pkg::*;
#(
  parameter int T_LEAD_MARK  = NEC_T_LEAD_MARK,
  parameter int T_LEAD_SPACE = NEC_T_LEAD_SPACE,
  parameter int T_REP_SPACE  = NEC_T_REP_SPACE,
  parameter int T_BIT_MARK   = NEC_T_BIT_MARK,
  parameter int T_ZERO_SPACE = NEC_T_ZERO_SPACE,
  parameter int T_ONE_SPACE  = NEC_T_ONE_SPACE,
  parameter int T_GAP        = NEC_T_GAP,
  parameter int CARRIER_HALF = NEC_CARRIER_HALF,
  parameter int CNT_W        = NEC_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       repeat_req,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_out,
  output logic       led_out
);

  // Terminal counts: a state lasting T cycles exits when the counter reads T-1
  localparam logic [CNT_W-1:0] LEAD_MARK_END  = CNT_W'(T_LEAD_MARK - 1);
  localparam logic [CNT_W-1:0] LEAD_SPACE_END = CNT_W'(T_LEAD_SPACE - 1);
  localparam logic [CNT_W-1:0] REP_SPACE_END  = CNT_W'(T_REP_SPACE - 1);
  localparam logic [CNT_W-1:0] BIT_MARK_END   = CNT_W'(T_BIT_MARK - 1);
  localparam logic [CNT_W-1:0] ZERO_SPACE_END = CNT_W'(T_ZERO_SPACE - 1);
  localparam logic [CNT_W-1:0] ONE_SPACE_END  = CNT_W'(T_ONE_SPACE - 1);
  localparam logic [CNT_W-1:0] GAP_END        = CNT_W'(T_GAP - 1);

  nec_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_idx;
  logic [31:0]      r_frame;
  logic             r_rep;
  logic             r_busy;
  logic             r_done;
  logic             r_ir;

  nec_state_t       w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [4:0]       w_idx_next;
  logic [31:0]      w_frame_next;
  logic             w_rep_next;
  logic             w_gap_end;
  logic             w_mark_next;
  logic             w_mark_entry;
  logic             w_led;

  // State, counter, bit index and latched frame; reset drops the line to idle immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_rep   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ir    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_frame <= w_frame_next;
      r_rep   <= w_rep_next;
      r_busy  <= (w_state_next != IDLE);
      r_done  <= w_gap_end;
      r_ir    <= ~w_mark_next;
    end
  end

  // Next-state logic: accept in IDLE, otherwise advance when the timed state expires
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_idx_next   = r_idx;
    w_frame_next = r_frame;
    w_rep_next   = r_rep;
    w_gap_end    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (start) begin
          w_frame_next = build_frame(addr, cmd);
          w_rep_next   = 1'b0;
          w_state_next = LEAD_MARK;
        end else if (repeat_req) begin
          w_rep_next   = 1'b1;
          w_state_next = LEAD_MARK;
        end
      end
      LEAD_MARK: begin
        if (r_cnt == LEAD_MARK_END) begin
          w_cnt_next   = '0;
          w_state_next = LEAD_SPACE;
        end
      end
      LEAD_SPACE: begin
        if (r_cnt == (r_rep ? REP_SPACE_END : LEAD_SPACE_END)) begin
          w_cnt_next = '0;
          if (r_rep) begin
            w_state_next = STOP_MARK;
          end else begin
            w_state_next = BIT_MARK;
            w_idx_next   = '0;
          end
        end
      end
      BIT_MARK: begin
        if (r_cnt == BIT_MARK_END) begin
          w_cnt_next   = '0;
          w_state_next = BIT_SPACE;
        end
      end
      BIT_SPACE: begin
        if (r_cnt == (r_frame[r_idx] ? ONE_SPACE_END : ZERO_SPACE_END)) begin
          w_cnt_next = '0;
          if (r_idx == 5'd31) begin
            w_state_next = STOP_MARK;
          end else begin
            w_state_next = BIT_MARK;
            w_idx_next   = r_idx + 5'd1;
          end
        end
      end
      STOP_MARK: begin
        if (r_cnt == BIT_MARK_END) begin
          w_cnt_next   = '0;
          w_state_next = GAP;
        end
      end
      GAP: begin
        if (r_cnt == GAP_END) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
          w_gap_end    = 1'b1;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  // Carrier runs during the coming mark and restarts its phase when a mark begins
  assign w_mark_next  = is_mark_state(w_state_next);
  assign w_mark_entry = w_mark_next & ~is_mark_state(r_state);

  nec_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (w_mark_next),
    .i_phase_reset(w_mark_entry),
    .o_led        (w_led)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign ir_out  = r_ir;
  assign led_out = w_led;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Scoreboard bench for nec_ir_tx at scaled timing. Stimulus pushes the
// expected mark/space/gap lengths; a monitor measures ir_out run lengths,
// the done position and the carrier, and pops/compares.
module tb_nec_ir_tx;

  localparam int LM = 16, LS = 8, RS = 4, BM = 2, ZS = 2, OS = 6, GP = 10, CH = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       repeat_req = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] cmd = 8'h00;
  logic       busy, done, ir_out, led_out;

  always #5 clk = ~clk;

  nec_ir_tx #(
    .T_LEAD_MARK (LM),
    .T_LEAD_SPACE(LS),
    .T_REP_SPACE (RS),
    .T_BIT_MARK  (BM),
    .T_ZERO_SPACE(ZS),
    .T_ONE_SPACE (OS),
    .T_GAP       (GP),
    .CARRIER_HALF(CH),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .repeat_req(repeat_req),
    .addr      (addr),
    .cmd       (cmd),
    .busy      (busy),
    .done      (done),
    .ir_out    (ir_out),
    .led_out   (led_out)
  );

  typedef enum int {K_LOW, K_HIGH, K_DONE, K_IDLE} kind_t;
  typedef struct {
    kind_t kind;
    int    len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void push(input kind_t k, input int l);
    exp_t e;
    e.kind = k;
    e.len  = l;
    exp_q.push_back(e);
  endfunction

  // Expected line shape of a full data frame for a hand-computed 32-bit word
  task automatic push_frame(input logic [31:0] f);
    push(K_LOW, LM);
    push(K_HIGH, LS);
    for (int i = 0; i < 32; i++) begin
      push(K_LOW, BM);
      push(K_HIGH, f[i] ? OS : ZS);
    end
    push(K_LOW, BM);
    push(K_DONE, GP);
  endtask

  task automatic push_repeat();
    push(K_LOW, LM);
    push(K_HIGH, RS);
    push(K_LOW, BM);
    push(K_DONE, GP);
  endtask

  task automatic pop_check(input kind_t k, input string name, input int act);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected event actual=%0d required=no_event", name, act);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, int'(k), int'(e.kind));
      check(name, act, e.len);
    end
  endtask

  // Monitor: measure run lengths on ir_out and check carrier every cycle
  initial begin
    logic prev_ir;
    logic prev_led;
    int   run;
    bit   in_frame;
    prev_ir  = 1'b1;
    prev_led = 1'b0;
    run      = 0;
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_ir  = 1'b1;
        prev_led = 1'b0;
        run      = 0;
        in_frame = 1'b0;
      end else begin
        if (ir_out != prev_ir) begin
          if (ir_out == 1'b0) begin
            if (exp_q.size() > 0 && exp_q[0].kind == K_IDLE)
              pop_check(K_IDLE, "idle_between_frames", run);
            else if (in_frame)
              pop_check(K_HIGH, "space_len", run);
            in_frame = 1'b1;
          end else if (in_frame) begin
            pop_check(K_LOW, "mark_len", run);
          end
          run = 1;
        end else begin
          run++;
        end
        if (ir_out)
          check("led_off_in_space", int'(led_out), 0);
        else if (prev_ir)
          check("led_mark_entry", int'(led_out), 1);
        else
          check("led_toggle", int'(led_out), int'(!prev_led));
        if (done) begin
          pop_check(K_DONE, "gap_len", run - 1);
          in_frame = 1'b0;
        end
        prev_ir  = ir_out;
        prev_led = led_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, int'(seen), 1);
  endtask

  // Stimulus
  initial begin
    int done_cnt;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ir", int'(ir_out), 1);
    check("reset_led", int'(led_out), 0);
    rst = 1'b0;
    tick();

    // Data frame addr=00 cmd=12 -> ED12FF00
    push_frame(32'hED12FF00);
    addr = 8'h00; cmd = 8'h12; start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", int'(busy), 1);
    check("accept_ir_low", int'(ir_out), 0);
    wait_done("frame_00_12", 1000);
    check("done_busy_low", int'(busy), 0);
    tick();
    check("done_single_cycle", int'(done), 0);

    // Repeat code only
    push_repeat();
    repeat_req = 1'b1;
    tick();
    repeat_req = 1'b0;
    check("repeat_busy", int'(busy), 1);
    wait_done("repeat", 200);
    tick();

    // start and repeat_req together: start wins, addr=3C cmd=0F -> F00FC33C
    push_frame(32'hF00FC33C);
    addr = 8'h3C; cmd = 8'h0F; start = 1'b1; repeat_req = 1'b1;
    tick();
    start = 1'b0; repeat_req = 1'b0;
    wait_done("frame_both_req", 1000);
    tick();

    // start held: back-to-back frames, mid-frame input changes ignored
    push_frame(32'hE51A5AA5);
    push(K_IDLE, GP + 1);
    push_frame(32'hEF10FE01);
    addr = 8'hA5; cmd = 8'h1A; start = 1'b1;
    tick();
    check("b2b_first_busy", int'(busy), 1);
    repeat (60) tick();
    addr = 8'h01; cmd = 8'h10; repeat_req = 1'b1;
    tick();
    repeat_req = 1'b0;
    wait_done("b2b_first", 1000);
    tick();
    check("b2b_reaccept_busy", int'(busy), 1);
    start = 1'b0;
    wait_done("b2b_second", 1000);
    tick();

    // Reset during bit 10 of a frame
    push_frame(32'hED12FF00);
    addr = 8'h00; cmd = 8'h12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (72) tick();
    check("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("abort_ir", int'(ir_out), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_led", int'(led_out), 0);
    check("abort_done", int'(done), 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < GP + 20; n++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // Full frame after the abort
    push_frame(32'hE51A5AA5);
    addr = 8'hA5; cmd = 8'h1A; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("frame_after_abort", 1000);
    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
- NEC-protocol infrared transmitter. It is the transmit end of the IR remote link whose receiver decodes 32-bit NEC frames into an 8-bit command.
- Serialises {~cmd, cmd, ~addr, addr} LSB-first into leader, 32 pulse-distance bits and a stop burst. It also generates the NEC repeat code.
- Two outputs:
  - ir_out: demodulated, idle-high/mark-low. Same polarity the receiver expects on its entrada input, so the two blocks connect back-to-back in loopback tests.
  - led_out: 38 kHz carrier-modulated, for the IR LED driver.

Parameters:
- T_LEAD_MARK, 450000, leader mark length in clk cycles (9 ms at 50 MHz)
- T_LEAD_SPACE, 225000, leader space for a data frame (4.5 ms)
- T_REP_SPACE, 112500, leader space for a repeat code (2.25 ms)
- T_BIT_MARK, 28125, mark length of every bit and of the stop burst (562.5 us)
- T_ZERO_SPACE, 28125, space length for a 0 bit
- T_ONE_SPACE, 84375, space length for a 1 bit (1.6875 ms)
- T_GAP, 1500000, minimum idle-high guard after each transmission (30 ms)
- CARRIER_HALF, 658, carrier half-period in cycles (about 38 kHz at 50 MHz)
- CNT_W, 21, width of the timing counter; must hold max(T_*) - 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a data frame; sampled only when busy=0
- repeat_req  in  1  request a repeat code; sampled only when busy=0
- addr  in  8  address byte; latched on accept
- cmd  in  8  command byte; latched on accept
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse when the guard gap has elapsed
- ir_out  out  1  demodulated line: 1 = space/idle, 0 = mark
- led_out  out  1  carrier-modulated LED drive: carrier during mark, 0 otherwise

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and has priority over everything.
- Reset values: state=IDLE, busy=0, done=0, ir_out=1, led_out=0, counter=0, bit index=0.
- Reset mid-frame: the line goes idle at the next edge. No partial stop burst and no done pulse.
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- Accept:
  - In IDLE, start=1 latches frame = {~cmd, cmd, ~addr, addr} and sets rep=0.
  - Otherwise, repeat_req=1 sets rep=1.
  - start wins if both are asserted.
  - On the accept edge, state goes to LEAD_MARK and busy=1. ir_out=0 from the next cycle.
  - start/repeat_req while busy=1 are ignored (no queue).
- Timing: each timed state lasts exactly its parameter in cycles. The counter loads 0 on state entry and the state exits when counter == T-1.
- ir_out is 0 in LEAD_MARK, BIT_MARK and STOP_MARK, and 1 in every other state.
- Transitions:
  - LEAD_MARK -> LEAD_SPACE. Length is T_REP_SPACE if rep, else T_LEAD_SPACE.
  - LEAD_SPACE -> STOP_MARK if rep, else BIT_MARK with bit index=0.
  - BIT_MARK -> BIT_SPACE. Length is T_ONE_SPACE if frame[idx], else T_ZERO_SPACE.
  - BIT_SPACE -> BIT_MARK with idx+1 while idx<31. At idx==31 -> STOP_MARK.
  - STOP_MARK -> GAP -> IDLE.
- done: pulses in the cycle GAP exits. busy=0 in that same cycle. A new start may be accepted on the following edge.
- Bit order: frame[0] (addr LSB) is sent first. Bits 16..23 carry cmd and bits 24..31 carry ~cmd, which is exactly the check the receiver applies.
- Total data-frame length (ir_out not idle plus gap):
  - T_LEAD_MARK + T_LEAD_SPACE + 32*T_BIT_MARK + n1*T_ONE_SPACE + (32-n1)*T_ZERO_SPACE + T_BIT_MARK + T_GAP, where n1 is the count of ones in frame.
  - n1 is always 16, so the frame length is constant.
- Carrier:
  - The phase resets to 1 on every mark entry.
  - led_out toggles every CARRIER_HALF cycles while ir_out=0.
  - led_out is forced 0 while ir_out=1.
- No glitch on ir_out: it is registered, and changes only at state boundaries.

Decomposition:
- Shared package nec_pkg:
  - state enum
  - default NEC timing constants
  - NEC command codes already used by the calculator: power 8'h12, clear-A 8'h0F, clear-all 8'h10, clear-B 8'h13, add 8'h1A, sub 8'h1E, sign 8'h0C
  - function build_frame(addr, cmd) returning the 32-bit word
- Sub-module nec_carrier_gen (enable, phase reset, led_out). The FSM and counter stay in nec_ir_tx.

Test Plan:
- Scaled parameters (LEAD_MARK=16, LEAD_SPACE=8, REP_SPACE=4, BIT_MARK=2, ZERO_SPACE=2, ONE_SPACE=6, GAP=10, CARRIER_HALF=1). Pulse start with addr=8'h00, cmd=8'h12 -> ir_out low 16 cycles, high 8, then 32 bits with space widths matching 32'hED12FF00 LSB-first, a 2-cycle stop mark, done one cycle after a 10-cycle gap.
- repeat_req only -> mark 16, space 4, mark 2, gap 10, done. No data bits.
- start held continuously -> back-to-back frames separated by exactly GAP plus one accept cycle. Pulses asserted mid-frame do not alter the frame.
- rst asserted at bit 10 -> ir_out=1, busy=0, led_out=0 next cycle, no done pulse. The next start produces a complete frame.
- Loopback at default parameters into the existing receiver with cmd=8'h1A -> receiver comando=8'h1A and nova_mensagem pulses once.
- Carrier check -> led_out toggles every cycle during marks, stays 0 during spaces, and starts at 1 on each mark entry.
